// File: rtl/siete_seg_pkg.sv
// Shared seven-segment definitions: FSM states, segment bit positions
// and the hex-to-segment table also used by the display driver.
package siete_seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high gfedcba pattern per hex value, entry 0 at the low end
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_a_hex.sv
// Reverse lookup of an active-high gfedcba pattern into a hex value.
module seg_a_hex
    import siete_seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic       hit,
    output logic [3:0] value
);

    always_comb begin
        hit   = 1'b0;
        value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (pat == HEX_SEG[i]) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/lector_siete_segmentos.sv
// Seven-segment bus reader: recovers per-digit hex value and dp.
// Optional LECTOR_SEG_ERR_CNT_EN adds a saturating err_cnt output.
module lector_siete_segmentos
    import siete_seg_pkg::*;
#(
    parameter int NUM_DIG        = 4,
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_DIG-1:0]     an,
    input  logic [7:0]             seg,
    input  logic                   clr_err,
    output logic [4*NUM_DIG-1:0]   digits,
    output logic [NUM_DIG-1:0]     dps,
    output logic                   upd,
    output logic [2:0]             upd_idx,
`ifdef LECTOR_SEG_ERR_CNT_EN
    output logic [7:0]             err_cnt,
`endif
    output logic                   err
);

    localparam logic [NUM_DIG-1:0] AN_INV  = {NUM_DIG{AN_ACTIVE_LOW}};
    localparam logic [7:0]         SEG_INV = {8{SEG_ACTIVE_LOW}};
    localparam logic [15:0]        STB     = 16'(STABLE_CYCLES);

    logic [NUM_DIG-1:0] an_s1, an_s2, an_n;
    logic [7:0]         seg_s1, seg_s2, seg_n;

    // Synchronizers idle at the inactive bus level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= AN_INV;
            an_s2  <= AN_INV;
            seg_s1 <= SEG_INV;
            seg_s2 <= SEG_INV;
        end else begin
            an_s1  <= an;
            an_s2  <= an_s1;
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
        end
    end

    assign an_n  = an_s2 ^ AN_INV;
    assign seg_n = seg_s2 ^ SEG_INV;

    logic [3:0] hot_cnt;
    logic [2:0] an_idx;
    logic       one_hot;

    always_comb begin
        hot_cnt = 4'd0;
        an_idx  = 3'd0;
        for (int i = 0; i < NUM_DIG; i++) begin
            if (an_n[i]) begin
                hot_cnt = hot_cnt + 4'd1;
                an_idx  = 3'(i);
            end
        end
    end

    assign one_hot = (hot_cnt == 4'd1);

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [NUM_DIG-1:0] an_q, an_d;
    logic [7:0]         pat_q, pat_d;
    logic [2:0]         idx_q, idx_d;
    logic               chg, relatch, capture;

    assign chg = (an_n != an_q) || (seg_n != pat_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            an_q    <= '0;
            pat_q   <= 8'd0;
            idx_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            an_q    <= an_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        an_d    = an_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        relatch = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            IDLE: begin
                relatch = one_hot;
            end
            SETTLE, HOLD: begin
                if (chg) begin
                    relatch = one_hot;
                    if (!one_hot) begin
                        state_d = IDLE;
                        cnt_d   = 16'd0;
                    end
                end else if (state_q == SETTLE) begin
                    if (cnt_q >= STB) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
        if (relatch) begin
            an_d    = an_n;
            pat_d   = seg_n;
            idx_d   = an_idx;
            cnt_d   = 16'd1;
            state_d = SETTLE;
        end
    end

    logic       hit;
    logic [3:0] value;
    logic       dec_err;

    seg_a_hex u_dec (
        .pat   (pat_q[6:0]),
        .hit   (hit),
        .value (value)
    );

    assign dec_err = capture && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits  <= '0;
            dps     <= '0;
            upd     <= 1'b0;
            upd_idx <= 3'd0;
        end else begin
            upd <= 1'b0;
            if (capture && hit) begin
                upd     <= 1'b1;
                upd_idx <= idx_q;
                for (int i = 0; i < NUM_DIG; i++) begin
                    if (idx_q == 3'(i)) begin
                        digits[4*i +: 4] <= value;
                        dps[i]           <= pat_q[SEG_DP];
                    end
                end
            end
        end
    end

    // A new error wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (dec_err) begin
            err <= 1'b1;
        end else if (clr_err) begin
            err <= 1'b0;
        end
    end

`ifdef LECTOR_SEG_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (dec_err) begin
            if (clr_err) begin
                err_cnt <= 8'd1;
            end else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end else if (clr_err) begin
            err_cnt <= 8'd0;
        end
    end
`endif

endmodule

// File: tb/tb_lector_siete_segmentos.sv
// Scoreboard bench for lector_siete_segmentos with directed vectors.
module tb_lector_siete_segmentos;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [7:0]  seg = 8'hFF;
    logic        clr_err = 1'b0;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic        upd;
    logic [2:0]  upd_idx;
    logic        err;
`ifdef LECTOR_SEG_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    lector_siete_segmentos #(
        .NUM_DIG        (4),
        .STABLE_CYCLES  (16),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .an      (an),
        .seg     (seg),
        .clr_err (clr_err),
        .digits  (digits),
        .dps     (dps),
        .upd     (upd),
        .upd_idx (upd_idx),
`ifdef LECTOR_SEG_ERR_CNT_EN
        .err_cnt (err_cnt),
`endif
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] idx;
        logic [3:0] val;
        logic       dp;
        int         at;
    } exp_t;

    exp_t sb[$];
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every upd strobe consumes one expected capture
    always @(negedge clk) begin
        if (rst_n && upd) begin
            if (sb.size() == 0) begin
                check("unexpected_upd", {29'd0, upd_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("upd_idx", {29'd0, upd_idx}, {29'd0, e.idx});
                check("upd_digit", {28'd0, digits[4*e.idx +: 4]},
                      {28'd0, e.val});
                check("upd_dp", {31'd0, dps[e.idx]}, {31'd0, e.dp});
                check("upd_cycle", cyc, e.at);
            end
        end
    end

    task automatic apply(input logic [3:0] hot, input logic [7:0] pat,
                         input int hold, input bit exp_u,
                         input logic [2:0] ei, input logic [3:0] ev);
        @(posedge clk);
        #1;
        an  = ~hot;
        seg = ~pat;
        if (exp_u) sb.push_back('{idx: ei, val: ev, dp: pat[7], at: cyc + 19});
        repeat (hold) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_digits", {16'd0, digits}, 32'd0);
        check("rst_dps", {28'd0, dps}, 32'd0);
        check("rst_upd", {31'd0, upd}, 32'd0);
        check("rst_upd_idx", {29'd0, upd_idx}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;

        apply(4'b0001, 8'h06, 20, 1'b1, 3'd0, 4'h1);
        @(negedge clk);
        check("t1_err", {31'd0, err}, 32'd0);
        check("t1_digits", {16'd0, digits}, 32'h0001);

        apply(4'b0001, 8'h77, 40, 1'b1, 3'd0, 4'hA);
        apply(4'b0010, 8'h7C, 40, 1'b1, 3'd1, 4'hB);
        apply(4'b0100, 8'hB9, 40, 1'b1, 3'd2, 4'hC);
        apply(4'b1000, 8'h5E, 40, 1'b1, 3'd3, 4'hD);
        @(negedge clk);
        check("scan_digits", {16'd0, digits}, 32'hDCBA);
        check("scan_dps", {28'd0, dps}, 32'b0100);

        for (int k = 0; k < 4; k++)
            apply(4'b0001, (k % 2 == 0) ? 8'h6F : 8'h7F, 10, 1'b0, 3'd0, 4'h0);
        @(negedge clk);
        check("toggle_digits", {16'd0, digits}, 32'hDCBA);
        apply(4'b0001, 8'h6F, 30, 1'b1, 3'd0, 4'h9);
        @(negedge clk);
        check("hold9_digits", {16'd0, digits}, 32'hDCB9);
        check("hold9_dps", {28'd0, dps}, 32'b0100);

        apply(4'b0010, 8'h49, 40, 1'b0, 3'd0, 4'h0);
        @(negedge clk);
        check("bad_err", {31'd0, err}, 32'd1);
        check("bad_digits", {16'd0, digits}, 32'hDCB9);
`ifdef LECTOR_SEG_ERR_CNT_EN
        check("bad_err_cnt", {24'd0, err_cnt}, 32'd1);
`endif
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(negedge clk);
        check("clr_err_before_edge", {31'd0, err}, 32'd1);
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        @(negedge clk);
        check("clr_err_after", {31'd0, err}, 32'd0);
`ifdef LECTOR_SEG_ERR_CNT_EN
        check("clr_err_cnt", {24'd0, err_cnt}, 32'd0);
`endif

        apply(4'b0011, 8'h06, 50, 1'b0, 3'd0, 4'h0);
        @(negedge clk);
        check("multi_an_err", {31'd0, err}, 32'd0);
        check("multi_an_digits", {16'd0, digits}, 32'hDCB9);

        apply(4'b0100, 8'h4F, 12, 1'b0, 3'd0, 4'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_digits", {16'd0, digits}, 32'd0);
        check("async_rst_dps", {28'd0, dps}, 32'd0);
        check("async_rst_upd", {31'd0, upd}, 32'd0);
        check("async_rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{idx: 3'd2, val: 4'h3, dp: 1'b0, at: cyc + 19});
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("post_rst_digits", {16'd0, digits}, 32'h0300);
        check("sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
